// File: rtl/modexp_seq_pkg.sv
// ============================================================================
// modexp_seq_pkg : shared state encoding for the modular-exponentiation engine
// Revision       : 1.0
// ============================================================================
`default_nettype none

package modexp_seq_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_REDUCE = 3'd2,
    S_MUL    = 3'd3,
    S_SQR    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/modexp_seq_modmul_blakley.sv
// ============================================================================
// modmul_blakley : interleaved MSB-first modular multiplier, acc = x*y mod m
// Revision       : 1.0
// ============================================================================
`default_nettype none

module modmul_blakley #(
  parameter int NW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [NW-1:0] x,
  input  logic [NW-1:0] y,
  input  logic [NW-1:0] m,
  output logic [NW-1:0] acc,
  output logic          done
);

  localparam int CW = $clog2(NW + 1);

  logic [NW+1:0] acc_q, acc_d;
  logic [NW-1:0] x_q, x_d, y_q, y_d, m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  logic [NW+1:0] op_acc, op_y, op_m, dbl, sum;
  logic          op_bit;

  // The first step runs in the go cycle straight off the inputs, so a full
  // product takes exactly NW cycles and the last step is visible on acc.
  always_comb begin
    op_acc = go ? '0 : acc_q;
    op_bit = go ? x[NW-1] : x_q[NW-1];
    op_y   = go ? {2'b00, y} : {2'b00, y_q};
    op_m   = go ? {2'b00, m} : {2'b00, m_q};

    dbl = op_acc << 1;
    if (dbl >= op_m) dbl = dbl - op_m;
    sum = op_bit ? (dbl + op_y) : dbl;
    if (sum >= op_m) sum = sum - op_m;
  end

  always_comb begin
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (go) begin
      acc_d    = sum;
      x_d      = x << 1;
      y_d      = y;
      m_d      = m;
      cnt_d    = CW'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = sum;
      x_d   = x_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(NW - 1)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign acc  = sum[NW-1:0];
  assign done = active_q && !go && (cnt_q == CW'(NW - 1));

endmodule

`default_nettype wire

// File: rtl/modexp_seq.sv
// ============================================================================
// modexp_seq : right-to-left square-and-multiply modular exponentiation
// Revision   : 1.0
// ============================================================================
`default_nettype none

module modexp_seq
  import modexp_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   base,
  input  logic [2*WIDTH-1:0]   exponent,
  input  logic [2*WIDTH-1:0]   modulus,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 finish
);

  localparam int NW = 2 * WIDTH;

  state_t        state_q, state_d;
  logic [NW-1:0] base_q, base_d, e_q, e_d, m_q, m_d;
  logic [NW-1:0] r_q, r_d, b_q, b_d, result_q, result_d;
  logic          busy_q, busy_d, finish_q, finish_d, go_q, go_d;

  logic [NW-1:0] mm_x, mm_y, mm_acc;
  logic          mm_done;

  // REDUCE multiplies base by 1 so a base >= modulus is folded in range.
  always_comb begin
    mm_x = base_q;
    mm_y = NW'(1);
    case (state_q)
      S_MUL: begin
        mm_x = r_q;
        mm_y = b_q;
      end
      S_SQR: begin
        mm_x = b_q;
        mm_y = b_q;
      end
      default: ;
    endcase
  end

  modmul_blakley #(.NW(NW)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .go    (go_q),
    .x     (mm_x),
    .y     (mm_y),
    .m     (m_q),
    .acc   (mm_acc),
    .done  (mm_done)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    e_d      = e_q;
    m_d      = m_q;
    r_d      = r_q;
    b_d      = b_q;
    result_d = result_q;
    busy_d   = busy_q;
    finish_d = finish_q;
    go_d     = 1'b0;
    if (start) begin
      state_d  = S_LOAD;
      base_d   = base;
      e_d      = exponent;
      m_d      = modulus;
      busy_d   = 1'b1;
      finish_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          r_d = NW'(1);
          if (m_q <= NW'(1)) begin
            r_d     = '0;
            state_d = S_DONE;
          end else if (e_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REDUCE;
            go_d    = 1'b1;
          end
        end
        S_REDUCE: if (mm_done) begin
          b_d     = mm_acc;
          go_d    = 1'b1;
          state_d = e_q[0] ? S_MUL : S_SQR;
        end
        // No squaring once the remaining exponent bits above this one are zero.
        S_MUL: if (mm_done) begin
          r_d = mm_acc;
          if (e_q[NW-1:1] == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SQR;
            go_d    = 1'b1;
          end
        end
        S_SQR: if (mm_done) begin
          b_d     = mm_acc;
          e_d     = e_q >> 1;
          go_d    = 1'b1;
          state_d = e_q[1] ? S_MUL : S_SQR;
        end
        S_DONE: begin
          result_d = r_q;
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      e_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      e_q      <= e_d;
      m_q      <= m_d;
      r_q      <= r_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      go_q     <= go_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_modexp_seq.sv
// ============================================================================
// tb_modexp_seq : directed self-checking bench for modexp_seq (WIDTH=64)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_modexp_seq;

  localparam int WIDTH = 64;
  localparam int NW    = 2 * WIDTH;
  localparam int LIMIT = 5000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] base = '0;
  logic [NW-1:0] exponent = '0;
  logic [NW-1:0] modulus = '0;
  logic [NW-1:0] result;
  logic          busy;
  logic          finish;

  int            checks = 0;
  int            passed = 0;
  logic [NW-1:0] prev_res = '0;

  always #5 clk = ~clk;

  modexp_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .finish   (finish)
  );

  task automatic pulse_start(input logic [NW-1:0] b, input logic [NW-1:0] e, input logic [NW-1:0] m);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = '1; exponent = '1; modulus = '1;
  endtask

  task automatic run_job(input logic [NW-1:0] b, input logic [NW-1:0] e, input logic [NW-1:0] m,
                         input logic [NW-1:0] r_exp, input int lat_exp, input string tag);
    int cyc;
    bit busy_ok;
    bit hold_ok;
    pulse_start(b, e, m);
    cyc = 0;
    checks++;
    if ({busy, finish} !== 2'b10)
      $display("FAIL %s start_ack: busy=%b finish=%b required busy=1 finish=0", tag, busy, finish);
    else passed++;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (finish !== 1'b1 && cyc < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (result !== prev_res) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!(busy_ok && hold_ok))
      $display("FAIL %s busy_hold: busy_ok=%b hold_ok=%b required 1 1", tag, busy_ok, hold_ok);
    else passed++;
    checks++;
    if (cyc != lat_exp) $display("FAIL %s latency: got %0d required %0d", tag, cyc, lat_exp);
    else passed++;
    checks++;
    if (result !== r_exp) $display("FAIL %s result: got %0d required %0d", tag, result, r_exp);
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, finish, result} !== {1'b0, 1'b1, r_exp})
      $display("FAIL %s post: busy=%b finish=%b result=%0d required 0 1 %0d", tag, busy, finish, result, r_exp);
    else passed++;
    prev_res = r_exp;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0) $display("FAIL reset_result: got %0d required 0", result); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    checks++;
    if (finish !== 1'b0) $display("FAIL reset_finish: got %b required 0", finish); else passed++;
    reset = 1'b0;
    prev_res = '0;
  endtask

  task automatic test_basic();
    run_job(NW'(4), NW'(13), NW'(497), NW'(445), 898, "t1");
  endtask

  task automatic test_rsa_round_trip();
    run_job(NW'(65), NW'(17), NW'(3233), NW'(2790), 898, "t2_enc");
    run_job(NW'(2790), NW'(2753), NW'(3233), NW'(65), 2178, "t2_dec");
  endtask

  task automatic test_trivial();
    run_job(NW'(5), NW'(0), NW'(7), NW'(1), 2, "t3_exp0");
    run_job(NW'(5), NW'(3), NW'(1), NW'(0), 2, "t3_mod1");
    run_job(NW'(5), NW'(3), NW'(0), NW'(0), 2, "t3_mod0");
  endtask

  task automatic test_reduce();
    run_job(NW'(1000), NW'(1), NW'(497), NW'(6), 258, "t4");
  endtask

  task automatic test_abort();
    bit fin_seen;
    pulse_start(NW'(4), NW'(13), NW'(497));
    fin_seen = 1'b0;
    for (int i = 0; i < 298; i++) begin
      if (finish !== 1'b0) fin_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (fin_seen) $display("FAIL t5_first_job: finish=1 seen required 0"); else passed++;
    run_job(NW'(2), NW'(10), NW'(1000), NW'(24), 770, "t5_abort");
  endtask

  task automatic test_reset_mid_op();
    pulse_start(NW'(4), NW'(13), NW'(497));
    repeat (300) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL t6_busy: got %b required 0", busy); else passed++;
    checks++;
    if (finish !== 1'b0) $display("FAIL t6_finish: got %b required 0", finish); else passed++;
    checks++;
    if (result !== '0) $display("FAIL t6_result: got %0d required 0", result); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_res = '0;
    run_job(NW'(4), NW'(13), NW'(497), NW'(445), 898, "t6_rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rsa_round_trip();
    test_trivial();
    test_reduce();
    test_abort();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
